mem_copy_ctrl: RTL and testbench
================================

# mem_copy_ctrl

Byte-copy / fill engine that sits directly upstream of the 4096 x 8 scratch memory and is the only master driving its address, write-data and Rd/Wr strobes. On a start request it either copies `len` bytes from `src_addr` to `dst_addr` or fills `len` bytes at `dst_addr` with a constant. It does this one byte per transaction, with registered, glitch-free strobes, and reports progress and completion to the control logic.

## Interface
- `ADDR_W`, 12: memory address width; addresses wrap modulo 2^ADDR_W.
- `DATA_W`, 8: memory data width.
- `clk`  in  1  single clock; all state changes on the rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  request; sampled only in IDLE.
- `fill_mode`  in  1  0 = copy, 1 = fill; latched with `start`.
- `src_addr`  in  ADDR_W  first source address (copy); latched with `start`.
- `dst_addr`  in  ADDR_W  first destination address; latched with `start`.
- `len`  in  ADDR_W+1  byte count, 0..4096; latched with `start`.
- `fill_data`  in  DATA_W  fill constant; latched with `start`.
- `abort`  in  1  stop the job early; honoured in READ/WRITE.
- `busy`  out  1  job in progress (READ/WRITE states).
- `done`  out  1  one-cycle pulse at job end, normal or aborted.
- `aborted`  out  1  with `done`: job ended by `abort`; holds until next `start`.
- `bytes_done`  out  ADDR_W+1  count of bytes written in the current or last job.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data (to memory Data_in).
- `mem_rd`  out  1  memory read strobe.
- `mem_wr`  out  1  memory write strobe.
- `mem_rdata`  in  DATA_W  memory read data (from memory Data_out); valid combinationally while `mem_rd`=1.

## Operation
- States are IDLE, READ, WRITE, DONE.
- All outputs are registers. Memory is combinational-write on level, so `mem_addr`/`mem_wdata` must never change while `mem_wr`=1 within a cycle.
- Reset values: state IDLE; `busy`, `done`, `aborted`, `mem_rd`, `mem_wr` = 0; `mem_addr`, `mem_wdata`, `bytes_done` = 0.
- IDLE with `start`=1:
  - Latch the inputs and clear `bytes_done` and `aborted`.
  - If `len`=0, go to DONE.
  - Otherwise go to READ (copy) or WRITE (fill).
- IDLE with `start`=0: stay in IDLE with all strobes 0.
- READ:
  - `mem_rd`=1, `mem_wr`=0, `mem_addr`=src pointer.
  - At the edge, capture `mem_rdata` into the data register, increment src pointer, go to WRITE.
- WRITE:
  - `mem_wr`=1, `mem_rd`=0, `mem_addr`=dst pointer, `mem_wdata`=data register (copy) or `fill_data` (fill).
  - At the edge, increment dst pointer and `bytes_done`.
  - If `bytes_done`+1 = `len`, go to DONE. Otherwise go to READ (copy) or stay in WRITE (fill).
- DONE: `done`=1 and `busy`=0 for exactly one cycle, then IDLE.
- `mem_rd` and `mem_wr` are never 1 in the same cycle. Both are 0 in IDLE and DONE, and `mem_addr`/`mem_wdata` return to 0 there.
- Pointers increment modulo 4096: 0xFFF+1 = 0x000. With `len`=4096 every location is touched once.
- Copies run in ascending order only; overlapping regions with dst > src are not protected (caller's responsibility).
- `abort`=1 in READ or WRITE:
  - The strobe of that cycle completes. A WRITE still commits and counts.
  - Next state is DONE with `aborted`=1.
  - `abort` is ignored in IDLE and DONE.
- `start` while not in IDLE is ignored.
- `rst` asserted mid-job: the next edge returns to reset values; no further strobe is issued.

## Timing
- `start` is sampled high at the end of cycle 0.
- Copy, L ≥ 1 bytes:
  - READ in cycles 1, 3, …, 2L−1; WRITE in cycles 2, 4, …, 2L.
  - `done` in cycle 2L+1; accepts a new `start` in cycle 2L+2.
- Fill, L ≥ 1 bytes: WRITE in cycles 1..L, `done` in cycle L+1.
- `len`=0: `done` in cycle 1, no strobes.
- `busy`=1 exactly in READ/WRITE cycles.
- `bytes_done` updates on the edge ending each WRITE and holds after DONE until the next `start`.

## Test plan
- Copy, preload mem[82]=232, mem[83]=17; start src=82, dst=300, len=2 -> rd@82 (cycle 1), wr 300←232 (cycle 2), rd@83, wr 301←17; `done` in cycle 5; `bytes_done`=2.
- Fill, dst=0xFFE, len=4, fill_data=0xA5 -> writes at 0xFFE, 0xFFF, 0x000, 0x001 in cycles 1–4; `done` in cycle 5; wrap verified.
- len=0 -> `done` in cycle 1, `mem_rd`/`mem_wr` never asserted, `bytes_done`=0.
- Copy len=5, `abort` high during the 2nd WRITE -> that write commits, `bytes_done`=2, DONE next cycle with `aborted`=1, no 3rd READ.
- `rst` high during a WRITE of a len=10 fill -> all outputs at reset values the next cycle, memory beyond the current byte untouched; `start` re-pulsed during `busy` is ignored.
- Checker on all tests: `mem_rd`&`mem_wr` never both 1; `mem_addr`/`mem_wdata` stable for every cycle with `mem_wr`=1.

Source files
------------

// File: rtl/mem_copy_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : mem_copy_ctrl_if
// Description : Bundle of the job-control handshake and the scratch-memory
//               bus seen by the byte copy / fill engine.
// Revision    : 1.0 - initial release
// ============================================================================
interface mem_copy_ctrl_if #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
);
    // Job control
    logic              start;
    logic              fill_mode;
    logic [ADDR_W-1:0] src_addr;
    logic [ADDR_W-1:0] dst_addr;
    logic [ADDR_W:0]   len;
    logic [DATA_W-1:0] fill_data;
    logic              abort;
    logic              busy;
    logic              done;
    logic              aborted;
    logic [ADDR_W:0]   bytes_done;
    // Memory bus
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_rd;
    logic              mem_wr;
    logic [DATA_W-1:0] mem_rdata;

    // Control logic / memory side
    modport master (
        output start, fill_mode, src_addr, dst_addr, len, fill_data, abort,
        output mem_rdata,
        input  busy, done, aborted, bytes_done,
        input  mem_addr, mem_wdata, mem_rd, mem_wr
    );

    // Engine side
    modport slave (
        input  start, fill_mode, src_addr, dst_addr, len, fill_data, abort,
        input  mem_rdata,
        output busy, done, aborted, bytes_done,
        output mem_addr, mem_wdata, mem_rd, mem_wr
    );
endinterface
`default_nettype wire

// File: rtl/mem_copy_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : mem_copy_ctrl
// Description : Byte copy / fill engine driving the 4096 x 8 scratch memory.
//               One byte per READ/WRITE transaction, all outputs registered.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_copy_ctrl #(
    parameter int ADDR_W = 12,
    parameter int DATA_W = 8
) (
    input  wire             clk,
    input  wire             rst,
    mem_copy_ctrl_if.slave  bus
);

    localparam logic [1:0] c_ST_IDLE  = 2'd0;
    localparam logic [1:0] c_ST_READ  = 2'd1;
    localparam logic [1:0] c_ST_WRITE = 2'd2;
    localparam logic [1:0] c_ST_DONE  = 2'd3;

    localparam logic [ADDR_W-1:0] c_ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
    localparam logic [ADDR_W:0]   c_CNT_ONE  = {{ADDR_W{1'b0}}, 1'b1};

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;

    // Latched job parameters and working pointers
    logic              r_fill;
    logic [DATA_W-1:0] r_fill_data;
    logic [ADDR_W:0]   r_len;
    logic [ADDR_W-1:0] r_src;
    logic [ADDR_W-1:0] r_dst;
    logic [DATA_W-1:0] r_data;
    logic [ADDR_W:0]   r_bytes_done;
    logic              r_aborted;

    // Registered outputs and their next values
    logic              r_busy,      w_busy_nxt;
    logic              r_done,      w_done_nxt;
    logic              r_mem_rd,    w_mem_rd_nxt;
    logic              r_mem_wr,    w_mem_wr_nxt;
    logic [ADDR_W-1:0] r_mem_addr,  w_mem_addr_nxt;
    logic [DATA_W-1:0] r_mem_wdata, w_mem_wdata_nxt;

    logic              w_last;
    logic              w_fill_sel;
    logic [DATA_W-1:0] w_fill_val;

    // The byte being written now is the last one of the job
    assign w_last     = ((r_bytes_done + c_CNT_ONE) == r_len);
    // In IDLE the job parameters come straight from the request
    assign w_fill_sel = (r_state == c_ST_IDLE) ? bus.fill_mode : r_fill;
    assign w_fill_val = (r_state == c_ST_IDLE) ? bus.fill_data : r_fill_data;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= c_ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_ST_IDLE: begin
                if (bus.start) begin
                    if (bus.len == '0)      w_state_nxt = c_ST_DONE;
                    else if (bus.fill_mode) w_state_nxt = c_ST_WRITE;
                    else                    w_state_nxt = c_ST_READ;
                end
            end
            c_ST_READ: begin
                w_state_nxt = bus.abort ? c_ST_DONE : c_ST_WRITE;
            end
            c_ST_WRITE: begin
                if (bus.abort || w_last) w_state_nxt = c_ST_DONE;
                else if (r_fill)         w_state_nxt = c_ST_WRITE;
                else                     w_state_nxt = c_ST_READ;
            end
            c_ST_DONE: begin
                w_state_nxt = c_ST_IDLE;
            end
            default: begin
                w_state_nxt = c_ST_IDLE;
            end
        endcase
    end

    // Output decode: values the output registers take for the coming state,
    // so strobes, address and data all change together on the clock edge
    always_comb begin
        w_busy_nxt      = 1'b0;
        w_done_nxt      = 1'b0;
        w_mem_rd_nxt    = 1'b0;
        w_mem_wr_nxt    = 1'b0;
        w_mem_addr_nxt  = '0;
        w_mem_wdata_nxt = '0;
        case (w_state_nxt)
            c_ST_READ: begin
                w_busy_nxt     = 1'b1;
                w_mem_rd_nxt   = 1'b1;
                w_mem_addr_nxt = (r_state == c_ST_IDLE) ? bus.src_addr : r_src;
            end
            c_ST_WRITE: begin
                w_busy_nxt   = 1'b1;
                w_mem_wr_nxt = 1'b1;
                case (r_state)
                    c_ST_IDLE:  w_mem_addr_nxt = bus.dst_addr;
                    c_ST_READ:  w_mem_addr_nxt = r_dst;
                    default:    w_mem_addr_nxt = r_dst + c_ADDR_ONE;
                endcase
                // Copy data is the byte being captured at this same edge
                if (w_fill_sel)                w_mem_wdata_nxt = w_fill_val;
                else if (r_state == c_ST_READ) w_mem_wdata_nxt = bus.mem_rdata;
                else                           w_mem_wdata_nxt = r_data;
            end
            c_ST_DONE: begin
                w_done_nxt = 1'b1;
            end
            default: begin
                w_done_nxt = 1'b0;
            end
        endcase
    end

    // Output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_mem_rd    <= 1'b0;
            r_mem_wr    <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
        end else begin
            r_busy      <= w_busy_nxt;
            r_done      <= w_done_nxt;
            r_mem_rd    <= w_mem_rd_nxt;
            r_mem_wr    <= w_mem_wr_nxt;
            r_mem_addr  <= w_mem_addr_nxt;
            r_mem_wdata <= w_mem_wdata_nxt;
        end
    end

    // Job parameters, pointers, byte count and abort flag
    always_ff @(posedge clk) begin
        if (rst) begin
            r_fill       <= 1'b0;
            r_fill_data  <= '0;
            r_len        <= '0;
            r_src        <= '0;
            r_dst        <= '0;
            r_data       <= '0;
            r_bytes_done <= '0;
            r_aborted    <= 1'b0;
        end else begin
            case (r_state)
                c_ST_IDLE: begin
                    if (bus.start) begin
                        r_fill       <= bus.fill_mode;
                        r_fill_data  <= bus.fill_data;
                        r_len        <= bus.len;
                        r_src        <= bus.src_addr;
                        r_dst        <= bus.dst_addr;
                        r_bytes_done <= '0;
                        r_aborted    <= 1'b0;
                    end
                end
                c_ST_READ: begin
                    r_data <= bus.mem_rdata;
                    r_src  <= r_src + c_ADDR_ONE;
                    if (bus.abort) r_aborted <= 1'b1;
                end
                c_ST_WRITE: begin
                    r_dst        <= r_dst + c_ADDR_ONE;
                    r_bytes_done <= r_bytes_done + c_CNT_ONE;
                    if (bus.abort) r_aborted <= 1'b1;
                end
                default: begin
                    r_aborted <= r_aborted;
                end
            endcase
        end
    end

    assign bus.busy       = r_busy;
    assign bus.done       = r_done;
    assign bus.aborted    = r_aborted;
    assign bus.bytes_done = r_bytes_done;
    assign bus.mem_addr   = r_mem_addr;
    assign bus.mem_wdata  = r_mem_wdata;
    assign bus.mem_rd     = r_mem_rd;
    assign bus.mem_wr     = r_mem_wr;

endmodule
`default_nettype wire

// File: tb/tb_mem_copy_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_copy_ctrl
// Description : Directed self-checking bench for mem_copy_ctrl with a
//               4096 x 8 memory model and a bus-protocol monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_copy_ctrl;

    logic clk;
    logic rst;
    int   checks;
    int   failures;
    int   prot_both;
    int   prot_stab;

    mem_copy_ctrl_if #(.ADDR_W(12), .DATA_W(8)) bus ();

    mem_copy_ctrl #(.ADDR_W(12), .DATA_W(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    // Memory model, level write committed at the end of the strobe cycle
    logic [7:0]  mem [0:4095];
    logic        pre_we;
    logic [11:0] pre_addr;
    logic [7:0]  pre_data;

    assign bus.mem_rdata = mem[bus.mem_addr];

    always @(posedge clk) begin
        if (bus.mem_wr)  mem[bus.mem_addr] <= bus.mem_wdata;
        else if (pre_we) mem[pre_addr]     <= pre_data;
    end

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Protocol monitor: exclusive strobes, address/data steady while writing
    logic        s_wr;
    logic [11:0] s_addr;
    logic [7:0]  s_wdata;

    always @(negedge clk) begin
        if (bus.mem_rd && bus.mem_wr) prot_both = prot_both + 1;
        s_wr    = bus.mem_wr;
        s_addr  = bus.mem_addr;
        s_wdata = bus.mem_wdata;
    end

    always @(posedge clk) begin
        if (s_wr && ((bus.mem_addr !== s_addr) || (bus.mem_wdata !== s_wdata) || (bus.mem_wr !== 1'b1)))
            prot_stab = prot_stab + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) else begin
            failures = failures + 1;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic preload(input logic [11:0] a, input logic [7:0] d);
        pre_addr = a;
        pre_data = d;
        pre_we   = 1'b1;
        @(negedge clk);
        pre_we   = 1'b0;
    endtask

    // Called at a negedge in cycle 0; returns at the negedge of cycle 1
    task automatic start_job(input logic fm, input logic [11:0] s, input logic [11:0] d,
                             input logic [12:0] l, input logic [7:0] fd);
        bus.fill_mode = fm;
        bus.src_addr  = s;
        bus.dst_addr  = d;
        bus.len       = l;
        bus.fill_data = fd;
        bus.start     = 1'b1;
        @(negedge clk);
        bus.start     = 1'b0;
    endtask

    // Strobe/address/data snapshot in the current cycle
    task automatic chk_bus(input string tag, input logic rd, input logic wr,
                           input logic [11:0] a, input logic [7:0] wd, input logic bz);
        chk({tag, "_rd"},   32'(bus.mem_rd),    32'(rd));
        chk({tag, "_wr"},   32'(bus.mem_wr),    32'(wr));
        chk({tag, "_addr"}, 32'(bus.mem_addr),  32'(a));
        chk({tag, "_wd"},   32'(bus.mem_wdata), 32'(wd));
        chk({tag, "_busy"}, 32'(bus.busy),      32'(bz));
    endtask

    initial begin
        checks    = 0;
        failures  = 0;
        prot_both = 0;
        prot_stab = 0;
        s_wr      = 1'b0;
        s_addr    = '0;
        s_wdata   = '0;
        pre_we    = 1'b0;
        pre_addr  = '0;
        pre_data  = '0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.fill_mode = 1'b0;
        bus.src_addr  = '0;
        bus.dst_addr  = '0;
        bus.len       = '0;
        bus.fill_data = '0;
        bus.abort     = 1'b0;

        repeat (3) @(negedge clk);
        chk_bus("rst", 1'b0, 1'b0, 12'h000, 8'h00, 1'b0);
        chk("rst_done", 32'(bus.done), 32'd0);
        chk("rst_abt",  32'(bus.aborted), 32'd0);
        chk("rst_cnt",  32'(bus.bytes_done), 32'd0);
        rst = 1'b0;

        // Copy 2 bytes 82 -> 300
        preload(12'd82, 8'd232);
        preload(12'd83, 8'd17);
        preload(12'd300, 8'h00);
        preload(12'd301, 8'h00);
        start_job(1'b0, 12'd82, 12'd300, 13'd2, 8'h00);
        chk_bus("cp_c1", 1'b1, 1'b0, 12'd82,  8'd0,   1'b1);
        @(negedge clk);
        chk_bus("cp_c2", 1'b0, 1'b1, 12'd300, 8'd232, 1'b1);
        @(negedge clk);
        chk_bus("cp_c3", 1'b1, 1'b0, 12'd83,  8'd0,   1'b1);
        chk("cp_c3_cnt", 32'(bus.bytes_done), 32'd1);
        @(negedge clk);
        chk_bus("cp_c4", 1'b0, 1'b1, 12'd301, 8'd17,  1'b1);
        @(negedge clk);
        chk_bus("cp_c5", 1'b0, 1'b0, 12'd0,   8'd0,   1'b0);
        chk("cp_done", 32'(bus.done), 32'd1);
        chk("cp_cnt",  32'(bus.bytes_done), 32'd2);
        chk("cp_abt",  32'(bus.aborted), 32'd0);
        @(negedge clk);
        chk("cp_done_off", 32'(bus.done), 32'd0);
        chk("cp_cnt_hold", 32'(bus.bytes_done), 32'd2);
        chk("cp_m300", 32'(mem[300]), 32'd232);
        chk("cp_m301", 32'(mem[301]), 32'd17);

        // Fill 4 bytes across the address wrap
        start_job(1'b1, 12'h000, 12'hFFE, 13'd4, 8'hA5);
        chk_bus("fl_c1", 1'b0, 1'b1, 12'hFFE, 8'hA5, 1'b1);
        @(negedge clk);
        chk_bus("fl_c2", 1'b0, 1'b1, 12'hFFF, 8'hA5, 1'b1);
        @(negedge clk);
        chk_bus("fl_c3", 1'b0, 1'b1, 12'h000, 8'hA5, 1'b1);
        @(negedge clk);
        chk_bus("fl_c4", 1'b0, 1'b1, 12'h001, 8'hA5, 1'b1);
        @(negedge clk);
        chk_bus("fl_c5", 1'b0, 1'b0, 12'h000, 8'h00, 1'b0);
        chk("fl_done", 32'(bus.done), 32'd1);
        chk("fl_cnt",  32'(bus.bytes_done), 32'd4);
        @(negedge clk);
        chk("fl_mFFE", 32'(mem[12'hFFE]), 32'hA5);
        chk("fl_mFFF", 32'(mem[12'hFFF]), 32'hA5);
        chk("fl_m000", 32'(mem[12'h000]), 32'hA5);
        chk("fl_m001", 32'(mem[12'h001]), 32'hA5);

        // Zero-length job
        start_job(1'b0, 12'd5, 12'd6, 13'd0, 8'h00);
        chk_bus("z_c1", 1'b0, 1'b0, 12'd0, 8'd0, 1'b0);
        chk("z_done", 32'(bus.done), 32'd1);
        chk("z_cnt",  32'(bus.bytes_done), 32'd0);
        @(negedge clk);
        chk("z_done_off", 32'(bus.done), 32'd0);

        // Copy 5 bytes, abort during the second WRITE
        for (int i = 0; i < 5; i++) preload(12'(10 + i), 8'(8'h11 + i));
        for (int i = 0; i < 5; i++) preload(12'(20 + i), 8'h55);
        start_job(1'b0, 12'd10, 12'd20, 13'd5, 8'h00);
        chk_bus("ab_c1", 1'b1, 1'b0, 12'd10, 8'h00, 1'b1);
        @(negedge clk);
        chk_bus("ab_c2", 1'b0, 1'b1, 12'd20, 8'h11, 1'b1);
        @(negedge clk);
        chk_bus("ab_c3", 1'b1, 1'b0, 12'd11, 8'h00, 1'b1);
        @(negedge clk);
        chk_bus("ab_c4", 1'b0, 1'b1, 12'd21, 8'h12, 1'b1);
        bus.abort = 1'b1;
        @(negedge clk);
        bus.abort = 1'b0;
        chk_bus("ab_c5", 1'b0, 1'b0, 12'd0, 8'h00, 1'b0);
        chk("ab_done", 32'(bus.done), 32'd1);
        chk("ab_abt",  32'(bus.aborted), 32'd1);
        chk("ab_cnt",  32'(bus.bytes_done), 32'd2);
        @(negedge clk);
        chk("ab_rd_after", 32'(bus.mem_rd), 32'd0);
        chk("ab_abt_hold", 32'(bus.aborted), 32'd1);
        chk("ab_m21", 32'(mem[21]), 32'h12);
        chk("ab_m22", 32'(mem[22]), 32'h55);

        // Fill 10 bytes, start re-pulsed while busy, reset mid-WRITE
        for (int i = 0; i < 10; i++) preload(12'(400 + i), 8'h00);
        start_job(1'b1, 12'd0, 12'd400, 13'd10, 8'h3C);
        chk_bus("rs_c1", 1'b0, 1'b1, 12'd400, 8'h3C, 1'b1);
        chk("rs_abt_clr", 32'(bus.aborted), 32'd0);
        @(negedge clk);
        bus.start     = 1'b1;
        bus.fill_data = 8'h77;
        bus.dst_addr  = 12'd900;
        bus.len       = 13'd0;
        @(negedge clk);
        bus.start     = 1'b0;
        chk_bus("rs_c3", 1'b0, 1'b1, 12'd402, 8'h3C, 1'b1);
        chk("rs_c3_cnt", 32'(bus.bytes_done), 32'd2);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        chk_bus("rs_c4", 1'b0, 1'b0, 12'd0, 8'h00, 1'b0);
        chk("rs_done", 32'(bus.done), 32'd0);
        chk("rs_cnt",  32'(bus.bytes_done), 32'd0);
        repeat (3) @(negedge clk);
        chk("rs_idle_wr", 32'(bus.mem_wr), 32'd0);
        chk("rs_m402", 32'(mem[402]), 32'h3C);
        chk("rs_m403", 32'(mem[403]), 32'h00);
        chk("rs_m409", 32'(mem[409]), 32'h00);

        chk("prot_rd_wr_excl", 32'(prot_both), 32'd0);
        chk("prot_wr_stable",  32'(prot_stab), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
